five_stage_hazard_detection_unit: RTL and testbench

Tracks the destination registers of the instructions in flight in execute, memory and writeback, and compares them against the source registers of the instruction in decode. It produces the per-stage `rs*_hazard_*` flags and `true_data_hazard` (load-use) that the five-stage bypass unit consumes, plus the decode stall request. It sits in the decode stage, directly upstream of the bypass unit, and keeps its own registered copy of pipeline destination state.

---
 rtl/five_stage_pkg.sv | 51 +++++
 rtl/five_stage_dest_tracker.sv | 51 +++++
 rtl/five_stage_hazard_detection_unit.sv | 152 +++++++++++++++
 tb/tb_five_stage_hazard_detection_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/five_stage_pkg.sv
// -----------------------------------------------------------------------------
// five_stage_pkg
//
// Purpose : Types and constants shared by the five-stage pipeline hazard
//           detection unit, its destination tracker and the bypass unit
//           downstream of it.
//
// Contents: REG_ADDR_W      - register-index width
//           NUM_TRACKED     - number of tracked stages (EX, MEM, WB)
//           STAGE_*         - tracker index of each stage
//           dest_entry_t    - tracker entry {valid, rd, regwrite, mem_read}
//           DEST_BUBBLE     - empty tracker entry (all zero)
//           bypass_sel_t    - bypass-select encodings used by the bypass unit
//           produces_reg()  - "does this entry forward to source register rs"
// -----------------------------------------------------------------------------
package five_stage_pkg;

    localparam int REG_ADDR_W  = 5;

    localparam int NUM_TRACKED = 3;
    localparam int STAGE_EX    = 0;
    localparam int STAGE_MEM   = 1;
    localparam int STAGE_WB    = 2;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  regwrite;
        logic                  mem_read;
    } dest_entry_t;

    localparam dest_entry_t DEST_BUBBLE = '0;

    // Operand source selection decoded by the bypass unit from the hazard
    // flags this block produces.
    typedef enum logic [1:0] {
        BYPASS_REGFILE   = 2'b00,
        BYPASS_EXECUTE   = 2'b01,
        BYPASS_MEMORY    = 2'b10,
        BYPASS_WRITEBACK = 2'b11
    } bypass_sel_t;

    // A tracked instruction is a producer for rs only if it really writes a
    // register and that register is not x0 (x0 reads as zero, so it can
    // never carry a dependency).
    function automatic logic produces_reg(input dest_entry_t           entry,
                                          input logic [REG_ADDR_W-1:0] rs);
        return entry.valid & entry.regwrite & (entry.rd != '0) & (entry.rd == rs);
    endfunction

endpackage : five_stage_pkg

// File: rtl/five_stage_dest_tracker.sv
// -----------------------------------------------------------------------------
// five_stage_dest_tracker
//
// Purpose : Registered copy of the destination state of the instructions in
//           execute, memory and writeback. Every cycle the entries shift one
//           stage down the pipe, the decode instruction (or a bubble) enters
//           execute, and the writeback entry falls off the end.
//
// Ports   : clock            - core clock
//           reset            - synchronous active-high reset, empties all entries
//           i_hold           - freeze all entries (data-memory back-pressure)
//           i_insert_bubble  - load a bubble into execute instead of decode
//           i_decode_entry   - destination state of the decode instruction
//           o_stage[]        - current entries, indexed by STAGE_EX/MEM/WB
// -----------------------------------------------------------------------------
module five_stage_dest_tracker
    import five_stage_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        i_hold,
    input  logic        i_insert_bubble,
    input  dest_entry_t i_decode_entry,
    output dest_entry_t o_stage [NUM_TRACKED]
);

    dest_entry_t r_stage      [NUM_TRACKED];
    dest_entry_t w_stage_next [NUM_TRACKED];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_TRACKED; gi++) begin : g_stage
            if (gi == STAGE_EX) begin : g_entry
                assign w_stage_next[gi] = i_insert_bubble ? DEST_BUBBLE : i_decode_entry;
            end else begin : g_shift
                assign w_stage_next[gi] = r_stage[gi-1];
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    r_stage[gi] <= DEST_BUBBLE;
                end else if (!i_hold) begin
                    r_stage[gi] <= w_stage_next[gi];
                end
            end

            assign o_stage[gi] = r_stage[gi];
        end
    endgenerate

endmodule : five_stage_dest_tracker

// File: rtl/five_stage_hazard_detection_unit.sv
// -----------------------------------------------------------------------------
// five_stage_hazard_detection_unit
//
// Purpose : Decode-stage hazard detection for a five-stage pipeline. Compares
//           the decode source registers against the destinations tracked in
//           execute, memory and writeback, flags every matching producer for
//           the bypass unit, detects load-use hazards (which cannot be
//           bypassed) and requests a one-cycle decode stall for them.
//
// Parameters:
//           CORE        - core index, identification only
//           REG_ADDR_W  - register-index width (must match the package width)
//
// Ports   : clock, reset           - core clock, synchronous active-high reset
//           decode_valid           - decode holds a real instruction
//           rs1_decode/rs2_decode  - decode source registers
//           rd_decode              - decode destination register
//           regwrite_decode        - decode instruction writes rd
//           mem_read_decode        - decode instruction is a load
//           flush_decode           - redirect kills the decode instruction
//           memory_stall           - whole pipeline frozen this cycle
//           rs{1,2}_hazard_{execute,memory,writeback}
//                                  - source matches the producer in that stage
//           true_data_hazard       - load-use hazard on either source
//           stall_decode           - hold PC/decode, inject a bubble
//           load_use_stalls        - saturating count of load-use stall cycles
// -----------------------------------------------------------------------------
module five_stage_hazard_detection_unit #(
    parameter int CORE       = 0,
    parameter int REG_ADDR_W = five_stage_pkg::REG_ADDR_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  decode_valid,
    input  logic [REG_ADDR_W-1:0] rs1_decode,
    input  logic [REG_ADDR_W-1:0] rs2_decode,
    input  logic [REG_ADDR_W-1:0] rd_decode,
    input  logic                  regwrite_decode,
    input  logic                  mem_read_decode,
    input  logic                  flush_decode,
    input  logic                  memory_stall,
    output logic                  rs1_hazard_execute,
    output logic                  rs1_hazard_memory,
    output logic                  rs1_hazard_writeback,
    output logic                  rs2_hazard_execute,
    output logic                  rs2_hazard_memory,
    output logic                  rs2_hazard_writeback,
    output logic                  true_data_hazard,
    output logic                  stall_decode,
    output logic [31:0]           load_use_stalls
);

    import five_stage_pkg::*;

    localparam logic [31:0] COUNT_MAX = 32'hFFFF_FFFF;

    // CORE only names this instance in hierarchy dumps; no logic depends on it.
    if (CORE < 0) begin : g_core_index_unused
    end

    // -------------------------------------------------------------------------
    // Destination tracker
    // -------------------------------------------------------------------------
    dest_entry_t w_decode_entry;
    dest_entry_t w_stage [NUM_TRACKED];
    logic        w_insert_bubble;
    logic        w_true_data_hazard;

    assign w_decode_entry = '{valid:    decode_valid,
                              rd:       rd_decode,
                              regwrite: regwrite_decode,
                              mem_read: mem_read_decode};

    // A killed, empty or stalled decode slot must not leave a producer in
    // execute. A flush coinciding with a load-use stall still yields exactly
    // one bubble because both conditions feed the same select.
    assign w_insert_bubble = ~decode_valid | flush_decode | w_true_data_hazard;

    five_stage_dest_tracker u_dest_tracker (
        .clock           (clock),
        .reset           (reset),
        .i_hold          (memory_stall),
        .i_insert_bubble (w_insert_bubble),
        .i_decode_entry  (w_decode_entry),
        .o_stage         (w_stage)
    );

    // -------------------------------------------------------------------------
    // Source comparators. Every stage is checked independently; the youngest
    // producer wins in the bypass unit, not here.
    // -------------------------------------------------------------------------
    logic [NUM_TRACKED-1:0] w_rs1_hit;
    logic [NUM_TRACKED-1:0] w_rs2_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_TRACKED; gi++) begin : g_cmp
            assign w_rs1_hit[gi] = decode_valid & produces_reg(w_stage[gi], rs1_decode);
            assign w_rs2_hit[gi] = decode_valid & produces_reg(w_stage[gi], rs2_decode);
        end
    endgenerate

    assign rs1_hazard_execute   = w_rs1_hit[STAGE_EX];
    assign rs1_hazard_memory    = w_rs1_hit[STAGE_MEM];
    assign rs1_hazard_writeback = w_rs1_hit[STAGE_WB];
    assign rs2_hazard_execute   = w_rs2_hit[STAGE_EX];
    assign rs2_hazard_memory    = w_rs2_hit[STAGE_MEM];
    assign rs2_hazard_writeback = w_rs2_hit[STAGE_WB];

    // -------------------------------------------------------------------------
    // Load-use detection. A load in execute has no data until the end of the
    // memory stage, so a dependent decode instruction must wait one cycle.
    // Only mem_read is required: the load's rd is what matters, and x0 never
    // counts as a dependency.
    // -------------------------------------------------------------------------
    logic w_ex_load_rs1;
    logic w_ex_load_rs2;

    assign w_ex_load_rs1 = (w_stage[STAGE_EX].rd == rs1_decode);
    assign w_ex_load_rs2 = (w_stage[STAGE_EX].rd == rs2_decode);

    assign w_true_data_hazard = decode_valid
                              & w_stage[STAGE_EX].valid
                              & w_stage[STAGE_EX].mem_read
                              & (w_stage[STAGE_EX].rd != '0)
                              & (w_ex_load_rs1 | w_ex_load_rs2);

    assign true_data_hazard = w_true_data_hazard;
    assign stall_decode     = w_true_data_hazard;

    // -------------------------------------------------------------------------
    // Load-use stall counter. A stall cycle frozen by memory_stall is not
    // counted until the pipeline actually moves, so each bubble is counted
    // exactly once. Saturates rather than wrapping.
    // -------------------------------------------------------------------------
    logic [31:0] r_load_use_stalls;
    logic        w_count_en;

    assign w_count_en = w_true_data_hazard & ~memory_stall
                      & (r_load_use_stalls != COUNT_MAX);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_load_use_stalls <= '0;
        end else if (w_count_en) begin
            r_load_use_stalls <= r_load_use_stalls + 32'd1;
        end
    end

    assign load_use_stalls = r_load_use_stalls;

endmodule : five_stage_hazard_detection_unit

// File: tb/tb_five_stage_hazard_detection_unit.sv
module tb_five_stage_hazard_detection_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        decode_valid;
    logic [4:0]  rs1_decode;
    logic [4:0]  rs2_decode;
    logic [4:0]  rd_decode;
    logic        regwrite_decode;
    logic        mem_read_decode;
    logic        flush_decode;
    logic        memory_stall;
    logic        rs1_hazard_execute;
    logic        rs1_hazard_memory;
    logic        rs1_hazard_writeback;
    logic        rs2_hazard_execute;
    logic        rs2_hazard_memory;
    logic        rs2_hazard_writeback;
    logic        true_data_hazard;
    logic        stall_decode;
    logic [31:0] load_use_stalls;

    always #5 clock = ~clock;

    five_stage_hazard_detection_unit #(
        .CORE       (0),
        .REG_ADDR_W (5)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .decode_valid         (decode_valid),
        .rs1_decode           (rs1_decode),
        .rs2_decode           (rs2_decode),
        .rd_decode            (rd_decode),
        .regwrite_decode      (regwrite_decode),
        .mem_read_decode      (mem_read_decode),
        .flush_decode         (flush_decode),
        .memory_stall         (memory_stall),
        .rs1_hazard_execute   (rs1_hazard_execute),
        .rs1_hazard_memory    (rs1_hazard_memory),
        .rs1_hazard_writeback (rs1_hazard_writeback),
        .rs2_hazard_execute   (rs2_hazard_execute),
        .rs2_hazard_memory    (rs2_hazard_memory),
        .rs2_hazard_writeback (rs2_hazard_writeback),
        .true_data_hazard     (true_data_hazard),
        .stall_decode         (stall_decode),
        .load_use_stalls      (load_use_stalls)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: a queue of in-flight instructions, youngest first
    // (index 0 = execute, 1 = memory, 2 = writeback).
    // ------------------------------------------------------------------
    typedef struct {
        bit v;
        int rd;
        bit rw;
        bit ld;
    } ent_t;

    ent_t        pipe[$];
    bit          m_known = 1'b0;
    logic [31:0] m_count = '0;

    function automatic ent_t bubble();
        ent_t e;
        e.v = 0; e.rd = 0; e.rw = 0; e.ld = 0;
        return e;
    endfunction

    function automatic bit m_hit(input int s, input logic [4:0] rs);
        return decode_valid && pipe[s].v && pipe[s].rw
            && pipe[s].rd != 0 && pipe[s].rd == int'(rs);
    endfunction

    function automatic bit m_tdh();
        return decode_valid && pipe[0].v && pipe[0].ld && pipe[0].rd != 0
            && (pipe[0].rd == int'(rs1_decode) || pipe[0].rd == int'(rs2_decode));
    endfunction

    initial begin
        for (int i = 0; i < 3; i++) pipe.push_back(bubble());
        forever begin
            @(negedge clock);
            if (m_known) begin
                check("model_rs1_ex",  {31'd0, rs1_hazard_execute},   {31'd0, m_hit(0, rs1_decode)});
                check("model_rs1_mem", {31'd0, rs1_hazard_memory},    {31'd0, m_hit(1, rs1_decode)});
                check("model_rs1_wb",  {31'd0, rs1_hazard_writeback}, {31'd0, m_hit(2, rs1_decode)});
                check("model_rs2_ex",  {31'd0, rs2_hazard_execute},   {31'd0, m_hit(0, rs2_decode)});
                check("model_rs2_mem", {31'd0, rs2_hazard_memory},    {31'd0, m_hit(1, rs2_decode)});
                check("model_rs2_wb",  {31'd0, rs2_hazard_writeback}, {31'd0, m_hit(2, rs2_decode)});
                check("model_tdh",     {31'd0, true_data_hazard},     {31'd0, m_tdh()});
                check("model_stall",   {31'd0, stall_decode},         {31'd0, m_tdh()});
                check("model_cnt",     load_use_stalls,               m_count);
            end
            // Advance the model with the inputs the next rising edge samples.
            if (reset) begin
                pipe.delete();
                for (int i = 0; i < 3; i++) pipe.push_back(bubble());
                m_count = '0;
                m_known = 1'b1;
            end else if (m_known && !memory_stall) begin
                ent_t nxt;
                bit   tdh;
                tdh = m_tdh();
                if (!decode_valid || flush_decode || tdh) begin
                    nxt = bubble();
                end else begin
                    nxt.v  = 1;
                    nxt.rd = int'(rd_decode);
                    nxt.rw = regwrite_decode;
                    nxt.ld = mem_read_decode;
                end
                pipe.push_front(nxt);
                void'(pipe.pop_back());
                if (tdh && m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus: one decode-slot transaction per clock cycle.
    // ------------------------------------------------------------------
    task automatic drive(input bit rst, input bit v, input int rs1, input int rs2,
                         input int rd, input bit rw, input bit ld, input bit fl, input bit ms);
        @(posedge clock);
        #1;
        reset           = rst;
        decode_valid    = v;
        rs1_decode      = 5'(rs1);
        rs2_decode      = 5'(rs2);
        rd_decode       = 5'(rd);
        regwrite_decode = rw;
        mem_read_decode = ld;
        flush_decode    = fl;
        memory_stall    = ms;
        @(negedge clock);
        $display("txn t=%0t rst=%0b v=%0b rs1=%0d rs2=%0d rd=%0d rw=%0b ld=%0b fl=%0b ms=%0b -> ex=%0b%0b mem=%0b%0b wb=%0b%0b tdh=%0b stall=%0b cnt=%0d",
                 $time, rst, v, rs1, rs2, rd, rw, ld, fl, ms,
                 rs1_hazard_execute, rs2_hazard_execute, rs1_hazard_memory, rs2_hazard_memory,
                 rs1_hazard_writeback, rs2_hazard_writeback, true_data_hazard, stall_decode,
                 load_use_stalls);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1; decode_valid = 0; rs1_decode = '0; rs2_decode = '0; rd_decode = '0;
        regwrite_decode = 0; mem_read_decode = 0; flush_decode = 0; memory_stall = 0;

        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        check("init_cnt", load_use_stalls, 32'd0);

        // ALU producer then consumer: add x5 ; sub x6,x5,x5 ; x5 read again
        drive(0, 1, 1, 2, 5, 1, 0, 0, 0);
        drive(0, 1, 5, 5, 6, 1, 0, 0, 0);
        check("alu_rs1_ex",  {31'd0, rs1_hazard_execute}, 32'd1);
        check("alu_rs2_ex",  {31'd0, rs2_hazard_execute}, 32'd1);
        check("alu_tdh",     {31'd0, true_data_hazard},   32'd0);
        drive(0, 1, 5, 0, 0, 0, 0, 0, 0);
        check("alu_rs1_mem", {31'd0, rs1_hazard_memory},  32'd1);
        check("alu_rs1_ex2", {31'd0, rs1_hazard_execute}, 32'd0);
        drive(0, 1, 5, 0, 0, 0, 0, 0, 0);
        check("alu_rs1_wb",  {31'd0, rs1_hazard_writeback}, 32'd1);
        idle(3);

        // Load to x0 never creates a hazard: lw x0 ; add x8,x0,x0
        drive(0, 1, 2, 0, 0, 1, 1, 0, 0);
        drive(0, 1, 0, 0, 8, 1, 0, 0, 0);
        check("x0_tdh",    {31'd0, true_data_hazard},   32'd0);
        check("x0_stall",  {31'd0, stall_decode},       32'd0);
        check("x0_rs1_ex", {31'd0, rs1_hazard_execute}, 32'd0);
        idle(1);
        check("x0_cnt", load_use_stalls, 32'd0);
        idle(2);

        // Load-use: lw x7 ; add x8,x7,x1 held one cycle in decode
        drive(0, 1, 2, 0, 7, 1, 1, 0, 0);
        drive(0, 1, 7, 1, 8, 1, 0, 0, 0);
        check("lu_tdh",   {31'd0, true_data_hazard}, 32'd1);
        check("lu_stall", {31'd0, stall_decode},     32'd1);
        check("lu_cnt0",  load_use_stalls,           32'd0);
        drive(0, 1, 7, 1, 8, 1, 0, 0, 0);
        check("lu_tdh2",    {31'd0, true_data_hazard},   32'd0);
        check("lu_rs1_mem", {31'd0, rs1_hazard_memory},  32'd1);
        check("lu_rs1_ex",  {31'd0, rs1_hazard_execute}, 32'd0);
        check("lu_cnt1",    load_use_stalls,             32'd1);
        idle(3);

        // Load-use under memory back-pressure: lw x9 ; add x10,x9,x9
        drive(0, 1, 3, 0, 9, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 9, 9, 10, 1, 0, 0, 1);
            check("ms_tdh", {31'd0, true_data_hazard}, 32'd1);
            check("ms_cnt", load_use_stalls,           32'd1);
        end
        drive(0, 1, 9, 9, 10, 1, 0, 0, 0);
        check("ms_tdh_rel", {31'd0, true_data_hazard}, 32'd1);
        check("ms_cnt_rel", load_use_stalls,           32'd1);
        drive(0, 1, 9, 9, 10, 1, 0, 0, 0);
        check("ms_tdh_done", {31'd0, true_data_hazard},  32'd0);
        check("ms_rs2_mem",  {31'd0, rs2_hazard_memory}, 32'd1);
        check("ms_cnt_done", load_use_stalls,            32'd2);
        idle(3);

        // Flush together with load-use: lw x11 ; add x12,x11,x0 flushed
        drive(0, 1, 4, 0, 11, 1, 1, 0, 0);
        drive(0, 1, 11, 0, 12, 1, 0, 1, 0);
        check("fl_tdh", {31'd0, true_data_hazard}, 32'd1);
        drive(0, 1, 11, 11, 13, 1, 0, 0, 0);
        check("fl_rs1_ex",  {31'd0, rs1_hazard_execute}, 32'd0);
        check("fl_rs2_ex",  {31'd0, rs2_hazard_execute}, 32'd0);
        check("fl_rs1_mem", {31'd0, rs1_hazard_memory},  32'd1);
        check("fl_cnt",     load_use_stalls,             32'd3);
        idle(3);

        // Reset in the middle of a load-use sequence
        drive(0, 1, 5, 0, 13, 1, 1, 0, 0);
        drive(0, 1, 13, 13, 14, 1, 0, 0, 0);
        check("rst_pre_tdh", {31'd0, true_data_hazard}, 32'd1);
        drive(1, 1, 13, 13, 14, 1, 0, 0, 0);
        check("rst_pre_cnt", load_use_stalls, 32'd4);
        drive(1, 1, 13, 13, 14, 1, 0, 0, 0);
        drive(0, 1, 13, 13, 14, 1, 0, 0, 0);
        check("rst_rs1_mem", {31'd0, rs1_hazard_memory}, 32'd0);
        check("rst_tdh",     {31'd0, true_data_hazard},  32'd0);
        check("rst_stall",   {31'd0, stall_decode},      32'd0);
        check("rst_cnt",     load_use_stalls,            32'd0);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_five_stage_hazard_detection_unit
